gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__CLKDIV_N_FUNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func.sv | 104 ++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func.sv
// Multi-channel glitch-free clock divider, NCH channels of period 2*(DIV+1).
// Define CLKDIV_PHASE_SYNC_EN to add the SYNC phase-align input.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic           CLK,
    input  logic           RN,
    input  logic [NCH-1:0] EN,
    input  logic [NCH*W-1:0] DIV,
`ifdef CLKDIV_PHASE_SYNC_EN
    input  logic           SYNC,
`endif
    output logic [NCH-1:0] Z,
    output logic [NCH-1:0] ACT,
    inout  wire            VDD,
    inout  wire            VSS
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         st  [NCH];
    logic [W-1:0]   cnt [NCH];
    logic [W-1:0]   sh  [NCH];

    // Supply pins carry no logic function.
    wire unused_pwr = VDD ^ VSS;

    // Per-channel divider: count to the shadow word, toggle, reload shadow.
    always_ff @(posedge CLK) begin
        for (int n = 0; n < NCH; n++) begin
            if (!RN) begin
                st[n]  <= IDLE;
                cnt[n] <= '0;
                sh[n]  <= '0;
                Z[n]   <= 1'b0;
                ACT[n] <= 1'b0;
            end
`ifdef CLKDIV_PHASE_SYNC_EN
            else if (SYNC && (st[n] != IDLE)) begin
                cnt[n] <= '0;
                sh[n]  <= DIV[n*W +: W];
                Z[n]   <= 1'b0;
                st[n]  <= (st[n] == RUN) ? RUN : IDLE;
                ACT[n] <= (st[n] == RUN);
            end
`endif
            else begin
                unique case (st[n])
                    IDLE: begin
                        cnt[n] <= '0;
                        Z[n]   <= 1'b0;
                        if (EN[n]) begin
                            st[n]  <= RUN;
                            sh[n]  <= DIV[n*W +: W];
                            ACT[n] <= 1'b1;
                        end else begin
                            ACT[n] <= 1'b0;
                        end
                    end
                    RUN, DRAIN: begin
                        if ((st[n] == RUN) && !EN[n] && !Z[n]) begin
                            // Low phase: stop at once, nothing to finish.
                            st[n]  <= IDLE;
                            cnt[n] <= '0;
                            ACT[n] <= 1'b0;
                        end else begin
                            if (cnt[n] == sh[n]) begin
                                cnt[n] <= '0;
                                sh[n]  <= DIV[n*W +: W];
                                Z[n]   <= ~Z[n];
                            end else begin
                                cnt[n] <= cnt[n] + 1'b1;
                            end
                            // A channel without EN is always in its high
                            // phase here; it idles once that phase ends.
                            if (!EN[n] && (cnt[n] == sh[n])) begin
                                st[n]  <= IDLE;
                                ACT[n] <= 1'b0;
                            end else if (!EN[n]) begin
                                st[n]  <= DRAIN;
                                ACT[n] <= 1'b1;
                            end else begin
                                st[n]  <= RUN;
                                ACT[n] <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        st[n]  <= IDLE;
                        cnt[n] <= '0;
                        Z[n]   <= 1'b0;
                        ACT[n] <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func.sv
// Scoreboard bench for the clock divider: a half-period model predicts
// Z/ACT after every edge; a monitor pops and compares each cycle.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func;

    localparam int NCH = 4;
    localparam int W   = 8;
`ifdef CLKDIV_PHASE_SYNC_EN
    localparam bit HAS_SYNC = 1'b1;
`else
    localparam bit HAS_SYNC = 1'b0;
`endif

    logic             CLK;
    logic             RN;
    logic [NCH-1:0]   EN;
    logic [NCH*W-1:0] DIV;
    logic             SYNC;
    logic [NCH-1:0]   Z;
    logic [NCH-1:0]   ACT;
    wire              vdd = 1'b1;
    wire              vss = 1'b0;

    gf180mcu_fd_sc_mcu7t5v0__clkdiv_n_func #(.NCH(NCH), .W(W)) dut (
        .CLK (CLK),
        .RN  (RN),
        .EN  (EN),
        .DIV (DIV),
`ifdef CLKDIV_PHASE_SYNC_EN
        .SYNC(SYNC),
`endif
        .Z   (Z),
        .ACT (ACT),
        .VDD (vdd),
        .VSS (vss)
    );

    typedef struct packed {
        logic [NCH-1:0] z;
        logic [NCH-1:0] act;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: mode 0=idle 1=run 2=drain, rem = edges left in this half period.
    int   m_mode [NCH];
    int   m_rem  [NCH];
    bit   m_z    [NCH];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: one expectation per rising edge.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if (Z !== e.z) begin
                fails++;
                $display("FAIL z t=%0t got=%b exp=%b", $time, Z, e.z);
            end
            tests++;
            if (ACT !== e.act) begin
                fails++;
                $display("FAIL act t=%0t got=%b exp=%b", $time, ACT, e.act);
            end
        end
    end

    // Predict the next edge from the current inputs, then wait for it.
    task automatic cyc();
        exp_t e;
        for (int n = 0; n < NCH; n++) begin
            int d;
            d = int'(DIV[n*W +: W]);
            if (!RN) begin
                m_mode[n] = 0;
                m_z[n]    = 1'b0;
                m_rem[n]  = 0;
            end else if (HAS_SYNC && SYNC && m_mode[n] != 0) begin
                m_z[n]    = 1'b0;
                m_rem[n]  = d + 1;
                m_mode[n] = (m_mode[n] == 1) ? 1 : 0;
            end else if (m_mode[n] == 0) begin
                if (EN[n]) begin
                    m_mode[n] = 1;
                    m_rem[n]  = d + 1;
                end
            end else if (m_mode[n] == 1 && !EN[n] && !m_z[n]) begin
                m_mode[n] = 0;
            end else begin
                m_rem[n]--;
                if (m_mode[n] == 2 && EN[n]) m_mode[n] = 1;
                else if (m_mode[n] == 1 && !EN[n]) m_mode[n] = 2;
                if (m_rem[n] == 0) begin
                    m_z[n]   = !m_z[n];
                    m_rem[n] = d + 1;
                    if (m_mode[n] == 2) m_mode[n] = 0;
                end
            end
            e.z[n]   = m_z[n];
            e.act[n] = (m_mode[n] != 0);
        end
        q.push_back(e);
        @(negedge CLK);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic set_div(input int n, input int v);
        DIV[n*W +: W] = W'(v);
    endtask

    initial begin
        RN = 1'b0; EN = '0; DIV = '0; SYNC = 1'b0;
        for (int n = 0; n < NCH; n++) begin
            m_mode[n] = 0; m_rem[n] = 0; m_z[n] = 1'b0;
        end
        @(negedge CLK);
        run(3);
        RN = 1'b1;
        run(2);

        // Channel 0: DIV=2 over ten periods.
        set_div(0, 2); EN[0] = 1'b1;
        run(62);

        // Channel 1: DIV=0, change to 4 during a high phase.
        set_div(1, 0); EN[1] = 1'b1;
        run(3);
        for (int i = 0; i < 4 && !m_z[1]; i++) cyc();
        set_div(1, 4);
        run(25);

        // Channel 2: drop EN mid high phase, then during low phase.
        set_div(2, 3); EN[2] = 1'b1;
        for (int i = 0; i < 40 && !(m_z[2] && m_rem[2] == 3); i++) cyc();
        EN[2] = 1'b0;
        run(10);
        EN[2] = 1'b1;
        for (int i = 0; i < 40 && !(m_z[2] == 0 && m_mode[2] == 1 && m_rem[2] < 4 && m_rem[2] > 1); i++) cyc();
        EN[2] = 1'b0;
        run(6);

        // Channel 3 at max divide, reset mid period, two full periods.
        EN = '1; set_div(3, 255);
        run(300);
        RN = 1'b0; run(1); RN = 1'b1;
        run(1030);

        // Phase alignment (only meaningful with SYNC compiled in).
        EN = 4'b0011; set_div(0, 1); set_div(1, 2);
        run(7);
        SYNC = 1'b1; run(1); SYNC = 1'b0;
        run(12);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < NCH; n++) begin
                if ($urandom_range(0, 19) == 0) EN[n] = ~EN[n];
                if ($urandom_range(0, 29) == 0) begin
                    if ($urandom_range(0, 9) == 0) set_div(n, $urandom_range(0, 255));
                    else set_div(n, $urandom_range(0, 6));
                end
            end
            RN   = ($urandom_range(0, 399) != 0);
            SYNC = ($urandom_range(0, 59) == 0);
            cyc();
        end
        RN = 1'b1; SYNC = 1'b0;

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
